// File: rtl/controle_varredura.sv
// Sweep controller for an external up/down position counter: loads a start
// position, then steps it back and forth between 0 and M-1 every T+2 cycles.
module controle_varredura #(
  parameter int M = 100,
  parameter int N = 7,
  parameter int T = 50
) (
  input  logic         clock,
  input  logic         zera_s,
  input  logic         iniciar,
  input  logic         parar,
  input  logic         continuar,
  input  logic [N-1:0] pos_ini,
  input  logic [N-1:0] Q,
  output logic         set_pos,
  output logic [N-1:0] D,
  output logic         vai,
  output logic         vem,
  output logic         enable_mov,
  output logic         direcao,
  output logic [7:0]   voltas,
  output logic [2:0]   estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    DECIDE  = 3'd2,
    AGUARDA = 3'd3,
    PASSO   = 3'd4,
    PARADO  = 3'd5
  } estado_t;

  localparam logic [N-1:0] TOPO  = N'(M - 1);
  localparam int           CW    = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(T - 1);
  localparam logic         MOVE  = (M > 1);

  estado_t       st;
  logic [CW-1:0] espera;

  // Load value is the start position clamped into the counter's range.
  assign D      = (pos_ini > TOPO) ? TOPO : pos_ini;
  assign estado = st;

  // Control priority: zera_s > parar > iniciar > continuar.
  // All strobes and enable_mov are registered and decoded from the next state,
  // so they line up exactly with the state that owns them.
  always_ff @(posedge clock) begin
    if (zera_s) begin
      st         <= OCIOSO;
      espera     <= '0;
      direcao    <= 1'b1;
      voltas     <= 8'd0;
      set_pos    <= 1'b0;
      vai        <= 1'b0;
      vem        <= 1'b0;
      enable_mov <= 1'b0;
    end else begin
      set_pos <= 1'b0;
      vai     <= 1'b0;
      vem     <= 1'b0;
      case (st)
        OCIOSO: begin
          enable_mov <= 1'b0;
          if (iniciar && !parar) begin
            st      <= CARREGA;
            set_pos <= 1'b1;
            direcao <= 1'b1;
          end
        end

        CARREGA: begin
          if (parar) begin
            st         <= PARADO;
            enable_mov <= 1'b0;
          end else begin
            st         <= DECIDE;
            enable_mov <= 1'b1;
          end
        end

        DECIDE: begin
          // Q already reflects the previous step here.
          if (direcao && (Q == TOPO)) begin
            direcao <= 1'b0;
          end else if (!direcao && (Q == '0)) begin
            direcao <= 1'b1;
            if (voltas != 8'hFF) voltas <= voltas + 8'd1;
          end
          if (parar) begin
            st         <= PARADO;
            enable_mov <= 1'b0;
          end else begin
            st         <= AGUARDA;
            espera     <= '0;
            enable_mov <= 1'b1;
          end
        end

        AGUARDA: begin
          if (parar) begin
            st         <= PARADO;
            enable_mov <= 1'b0;
          end else if (espera == ULTIMO) begin
            st         <= PASSO;
            vai        <= MOVE & direcao;
            vem        <= MOVE & ~direcao;
            enable_mov <= 1'b1;
          end else begin
            espera <= espera + CW'(1);
          end
        end

        PASSO: begin
          // A strobe already on the wire this cycle is taken by the counter.
          if (parar) begin
            st         <= PARADO;
            enable_mov <= 1'b0;
          end else begin
            st         <= DECIDE;
            enable_mov <= 1'b1;
          end
        end

        PARADO: begin
          if (parar) begin
            enable_mov <= 1'b0;
          end else if (iniciar) begin
            st         <= CARREGA;
            set_pos    <= 1'b1;
            direcao    <= 1'b1;
            enable_mov <= 1'b0;
          end else if (continuar) begin
            st         <= DECIDE;
            enable_mov <= 1'b1;
          end else begin
            enable_mov <= 1'b0;
          end
        end

        default: begin
          st         <= OCIOSO;
          enable_mov <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_varredura.sv
// Bench for controle_varredura: directed table, hand-written corner sequences
// and a random run checked against a step-phase model of the sweep.
module tb_controle_varredura;
  localparam int MA = 10;
  localparam int TA = 4;
  localparam int TB = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       zera_s = 1'b0, iniciar = 1'b0, parar = 1'b0, continuar = 1'b0;
  logic [6:0] pos_ini = '0;
  logic       cnt_rst = 1'b1;

  logic       set_pos_a, vai_a, vem_a, en_a, dir_a;
  logic [6:0] d_a, qa;
  logic [7:0] voltas_a;
  logic [2:0] estado_a;

  logic       set_pos_b, vai_b, vem_b, en_b, dir_b;
  logic [6:0] d_b, qb;
  logic [7:0] voltas_b;
  logic [2:0] estado_b;

  logic       set_pos_c, vai_c, vem_c, en_c, dir_c;
  logic [6:0] d_c;
  logic [6:0] qc = '0;
  logic [7:0] voltas_c;
  logic [2:0] estado_c;
  logic       m1_seen = 1'b0;

  controle_varredura #(.M(MA), .N(7), .T(TA)) dut_a (
    .clock(clock), .zera_s(zera_s), .iniciar(iniciar), .parar(parar),
    .continuar(continuar), .pos_ini(pos_ini), .Q(qa), .set_pos(set_pos_a),
    .D(d_a), .vai(vai_a), .vem(vem_a), .enable_mov(en_a), .direcao(dir_a),
    .voltas(voltas_a), .estado(estado_a));

  controle_varredura #(.M(MA), .N(7), .T(TB)) dut_b (
    .clock(clock), .zera_s(zera_s), .iniciar(iniciar), .parar(parar),
    .continuar(continuar), .pos_ini(pos_ini), .Q(qb), .set_pos(set_pos_b),
    .D(d_b), .vai(vai_b), .vem(vem_b), .enable_mov(en_b), .direcao(dir_b),
    .voltas(voltas_b), .estado(estado_b));

  controle_varredura #(.M(1), .N(7), .T(TB)) dut_c (
    .clock(clock), .zera_s(zera_s), .iniciar(iniciar), .parar(parar),
    .continuar(continuar), .pos_ini(pos_ini), .Q(qc), .set_pos(set_pos_c),
    .D(d_c), .vai(vai_c), .vem(vem_c), .enable_mov(en_c), .direcao(dir_c),
    .voltas(voltas_c), .estado(estado_c));

  // External counters driven by the strobes, with their own reset.
  always_ff @(posedge clock) begin
    if (cnt_rst) qa <= '0;
    else if (set_pos_a) qa <= d_a;
    else if (vai_a) qa <= qa + 7'd1;
    else if (vem_a) qa <= qa - 7'd1;
  end
  always_ff @(posedge clock) begin
    if (cnt_rst) qb <= '0;
    else if (set_pos_b) qb <= d_b;
    else if (vai_b) qb <= qb + 7'd1;
    else if (vem_b) qb <= qb - 7'd1;
  end
  always_ff @(posedge clock) if (vai_c || vem_c) m1_seen <= 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 loading, 2 sweeping, 3 halted; k is the cycle index
  // inside one step period (0 = decision, 1..T = wait, T+1 = step pulse).
  int m_mode = 0, m_k = 0, m_dir = 1, m_laps = 0, m_q = 0;

  function automatic int clamp(input int p);
    return (p > MA - 1) ? MA - 1 : p;
  endfunction

  function automatic int m_estado();
    if (m_mode == 0) return 0;
    if (m_mode == 1) return 1;
    if (m_mode == 3) return 5;
    if (m_k == 0) return 2;
    if (m_k == TA + 1) return 4;
    return 3;
  endfunction

  task automatic model_step();
    bit sp, up, dn;
    int q_old;
    sp = (m_mode == 1);
    up = (m_mode == 2) && (m_k == TA + 1) && (m_dir == 1);
    dn = (m_mode == 2) && (m_k == TA + 1) && (m_dir == 0);
    q_old = m_q;
    if (cnt_rst) m_q = 0;
    else if (sp) m_q = clamp(int'(pos_ini));
    else if (up) m_q = (m_q + 1) % 128;
    else if (dn) m_q = (m_q + 127) % 128;
    if (zera_s) begin
      m_mode = 0; m_k = 0; m_dir = 1; m_laps = 0;
    end else begin
      case (m_mode)
        0: if (iniciar && !parar) begin m_mode = 1; m_dir = 1; end
        1: begin
          if (parar) m_mode = 3;
          else begin m_mode = 2; m_k = 0; end
        end
        2: begin
          if (m_k == 0) begin
            if (m_dir == 1 && q_old == MA - 1) m_dir = 0;
            else if (m_dir == 0 && q_old == 0) begin
              m_dir = 1;
              if (m_laps < 255) m_laps++;
            end
          end
          if (parar) m_mode = 3;
          else m_k = (m_k == TA + 1) ? 0 : m_k + 1;
        end
        default: begin
          if (parar) m_mode = 3;
          else if (iniciar) begin m_mode = 1; m_dir = 1; end
          else if (continuar) begin m_mode = 2; m_k = 0; end
        end
      endcase
    end
  endtask

  task automatic tick();
    logic [31:0] act, exp;
    @(posedge clock);
    model_step();
    #1;
    act = {2'b0, estado_a, set_pos_a, vai_a, vem_a, en_a, dir_a, voltas_a, d_a, qa};
    exp = {2'b0, 3'(m_estado()), (m_mode == 1), (m_mode == 2 && m_k == TA + 1 && m_dir == 1),
           (m_mode == 2 && m_k == TA + 1 && m_dir == 0), (m_mode == 2), 1'(m_dir),
           8'(m_laps), 7'(clamp(int'(pos_ini))), 7'(m_q)};
    chk("model {estado,set_pos,vai,vem,en,dir,voltas,D,Q}", int'(act), int'(exp));
  endtask

  task automatic drive(input bit z, input bit i, input bit p, input bit c);
    zera_s = z; iniciar = i; parar = p; continuar = c;
  endtask

  typedef struct {
    bit z, i, p, c;
    int est;
    bit sp, en, dir;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int exp_pos[15];
    int idx, last, cyc, pending, q0, strobes, n, hits;
    bit found;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 0, 1, 1, 0, 0, 0, 1};
    tbl[2] = '{0, 1, 1, 0, 0, 0, 0, 1};
    tbl[3] = '{0, 1, 0, 0, 1, 1, 0, 1};
    tbl[4] = '{0, 1, 0, 0, 2, 0, 1, 1};
    tbl[5] = '{0, 1, 0, 0, 3, 0, 1, 1};
    tbl[6] = '{0, 1, 1, 0, 5, 0, 0, 1};
    tbl[7] = '{0, 0, 0, 1, 2, 0, 1, 1};
    tbl[8] = '{0, 0, 0, 0, 3, 0, 1, 1};
    tbl[9] = '{1, 1, 1, 1, 0, 0, 0, 1};

    // First edge resets the external counter and the DUTs together.
    drive(1, 0, 0, 0);
    tick();
    cnt_rst = 1'b0;

    pos_ini = 7'd3;
    for (int r = 0; r < 10; r++) begin
      drive(tbl[r].z, tbl[r].i, tbl[r].p, tbl[r].c);
      tick();
      chk($sformatf("table_row%0d", r), {estado_a, set_pos_a, en_a, dir_a},
          {3'(tbl[r].est), tbl[r].sp, tbl[r].en, tbl[r].dir});
    end
    chk("reset_voltas", voltas_a, 0);

    // Basic sweep from 3 up to 9 then down to 0, one step every T+2 cycles.
    for (int i = 0; i < 6; i++) exp_pos[i] = 4 + i;
    for (int i = 0; i < 9; i++) exp_pos[6 + i] = 8 - i;
    drive(1, 0, 0, 0); tick();
    pos_ini = 7'd3;
    drive(0, 1, 0, 0); tick();
    chk("load_set_pos", set_pos_a, 1);
    chk("load_D", d_a, 3);
    drive(0, 0, 0, 0); tick();
    chk("load_one_cycle", set_pos_a, 0);
    idx = 0; last = -1; cyc = 0; pending = -1;
    for (int c = 0; c < 200 && idx < 15; c++) begin
      tick(); cyc++;
      if (pending >= 0) begin chk("sweep_q", qa, pending); pending = -1; end
      if (vai_a || vem_a) begin
        chk("sweep_vai", vai_a, (idx < 6) ? 1 : 0);
        if (last >= 0) chk("sweep_period", cyc - last, TA + 2);
        last = cyc; pending = exp_pos[idx]; idx++;
      end
    end
    tick();
    if (pending >= 0) chk("sweep_q", qa, pending);
    chk("sweep_steps", idx, 15);

    // Start position above range: clamped to 9, first step goes down.
    drive(1, 0, 0, 0); tick();
    pos_ini = 7'd15;
    drive(0, 1, 0, 0); tick();
    chk("clamp_D", d_a, 9);
    drive(0, 0, 0, 0);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (vai_a || vem_a) found = 1;
    end
    chk("clamp_first_vem", {found, vem_a, dir_a}, 3'b110);
    tick();
    chk("clamp_q", qa, 8);

    // Halt during a step pulse, then resume.
    drive(1, 0, 0, 0); tick();
    pos_ini = 7'd3;
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 0);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (vai_a) found = 1;
    end
    chk("halt_saw_vai", found, 1);
    q0 = qa;
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    chk("halt_estado", estado_a, 5);
    chk("halt_q_inc", qa, q0 + 1);
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      strobes += vai_a + vem_a + set_pos_a + en_a;
    end
    chk("halt_quiet", strobes, 0);
    chk("halt_q_held", qa, q0 + 1);
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    chk("resume_decide", estado_a, 2);
    n = 1; found = 0;
    for (int c = 0; c < TA + 1 && !found; c++) begin
      tick(); n++;
      if (vai_a || vem_a) found = 1;
    end
    chk("resume_latency", found ? n : -1, TA + 2);
    chk("resume_dir_up", vai_a, 1);
    tick();
    chk("resume_q", qa, q0 + 2);

    // iniciar and parar together while running: parar wins, no load.
    drive(0, 1, 1, 0); tick();
    chk("ini_par_estado", estado_a, 5);
    chk("ini_par_no_load", set_pos_a, 0);
    drive(0, 0, 0, 0); tick();
    chk("ini_par_stays", estado_a, 5);

    // Round-trip counting on the T=1 instance, up to saturation.
    drive(1, 0, 0, 0); tick();
    pos_ini = 7'd0;
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 0);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (voltas_b == 8'd1) found = 1;
    end
    chk("lap_first", {found, dir_b, qb}, {1'b1, 1'b1, 7'd0});
    hits = 0;
    for (int c = 0; c < 300 * 18 * (TB + 2); c++) tick();
    chk("lap_saturate", voltas_b, 255);

    // Reset mid-wait.
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (estado_a == 3'd3) found = 1;
    end
    chk("rst_in_wait_reached", found, 1);
    chk("rst_voltas_nonzero", (voltas_a != 0) ? 1 : 0, 1);
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("rst_state", {estado_a, set_pos_a, vai_a, vem_a, en_a, dir_a}, {3'd0, 5'b00001});
    chk("rst_voltas", voltas_a, 0);
    chk("rst_voltas_b", voltas_b, 0);

    // Random control activity against the model.
    for (int c = 0; c < 4000; c++) begin
      zera_s    = ($urandom_range(0, 199) == 0);
      iniciar   = ($urandom_range(0, 39) == 0);
      parar     = ($urandom_range(0, 29) == 0);
      continuar = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) pos_ini = 7'($urandom_range(0, 127));
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    chk("m1_no_strobe", m1_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
